// File: rtl/issue_ctrl.sv
// Issue scheduler: picks none/single/dual issue from the two FIFO head entries.
// Define ISSUE_PERF_CNT_EN to build the dual/single/bubble performance counters.
module issue_ctrl #(
  parameter int WAIT_MAX = 2,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_valid_0,
  input  logic             fifo_valid_1,
  input  logic [31:0]      fifo_inst_0,
  input  logic [31:0]      fifo_inst_1,
  input  logic             fifo_ex_0,
  input  logic             fifo_ex_1,
  input  logic             ds_allowin,
  input  logic             ds_flush,
  output logic [1:0]       issue_mode,
  output logic             slot0_is_delay_slot,
  output logic [CNT_W-1:0] perf_dual_cnt,
  output logic [CNT_W-1:0] perf_single_cnt,
  output logic [CNT_W-1:0] perf_bubble_cnt
);

  localparam int WC_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WC_W-1:0] WAIT_LIM = WC_W'(WAIT_MAX);

  typedef enum logic {
    IDLE,
    DS_PEND
  } state_t;

  typedef enum logic [1:0] {
    MODE_NONE   = 2'b00,
    MODE_SINGLE = 2'b01,
    MODE_DUAL   = 2'b10
  } mode_t;

  state_t          state;
  logic [WC_W-1:0] wait_cnt;
  mode_t           mode;

  // A destination of 0 doubles as "no destination", since $0 is never written.
  function automatic logic [4:0] dest_of(input logic [5:0] op, input logic [4:0] rt,
                                         input logic [4:0] rd);
    logic [4:0] d;
    d = 5'd0;
    if (op == 6'b000000)
      d = rd;
    else if (op[5:3] == 3'b001 || op[5:3] == 3'b100)
      d = rt;
    else if (op == 6'b000011 || (op == 6'b000001 && (rt == 5'b10000 || rt == 5'b10001)))
      d = 5'd31;
    return d;
  endfunction

  // Returns {branch, muldiv, priv} for one instruction word.
  function automatic logic [2:0] class_of(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [5:0] func);
    logic br, md, pv;
    br = (op[5:2] == 4'b0001) || (op == 6'b000010) || (op == 6'b000011)
      || (op == 6'b000001 && (rt == 5'b00000 || rt == 5'b00001 ||
                              rt == 5'b10000 || rt == 5'b10001))
      || (op == 6'b000000 && (func == 6'b001000 || func == 6'b001001));
    md = (op == 6'b000000) && (func[5:3] == 3'b011 || func[5:2] == 4'b0100);
    pv = (op == 6'b010000)
      || (op == 6'b000000 && (func == 6'b001100 || func == 6'b001101));
    return {br, md, pv};
  endfunction

  logic [5:0] op0, op1, func0, func1;
  logic [4:0] rt0, rd0, rs1, rt1, dest0;
  logic       branch0, muldiv0, priv0, mem0;
  logic       branch1, muldiv1, priv1, mem1;
  logic       raw_hazard, pair_ok;
  logic       unused_inst_bits;

  assign op0   = fifo_inst_0[31:26];
  assign rt0   = fifo_inst_0[20:16];
  assign rd0   = fifo_inst_0[15:11];
  assign func0 = fifo_inst_0[5:0];
  assign op1   = fifo_inst_1[31:26];
  assign rs1   = fifo_inst_1[25:21];
  assign rt1   = fifo_inst_1[20:16];
  assign func1 = fifo_inst_1[5:0];

  assign unused_inst_bits = ^{fifo_inst_0[25:21], fifo_inst_0[10:6], fifo_inst_1[15:6]};

  assign dest0                       = dest_of(op0, rt0, rd0);
  assign {branch0, muldiv0, priv0}   = class_of(op0, rt0, func0);
  assign {branch1, muldiv1, priv1}   = class_of(op1, rt1, func1);
  assign mem0                        = (op0[5:4] == 2'b10);
  assign mem1                        = (op1[5:4] == 2'b10);

  assign raw_hazard = (dest0 != 5'd0) && (dest0 == rs1 || dest0 == rt1);

  assign pair_ok = fifo_valid_0 && fifo_valid_1 && !fifo_ex_0 && !fifo_ex_1
                && !priv0 && !priv1 && !branch1 && !raw_hazard
                && !(mem0 && mem1) && !(muldiv0 && muldiv1);

  // Issue decision is combinational on the current FIFO head; flush and stall win.
  always_comb begin
    mode = MODE_NONE;
    if (!ds_flush && ds_allowin && fifo_valid_0) begin
      if (state == DS_PEND)
        mode = MODE_SINGLE;
      else if (pair_ok)
        mode = MODE_DUAL;
      else if (!branch0 || fifo_valid_1 || wait_cnt >= WAIT_LIM)
        mode = MODE_SINGLE;
    end
  end

  assign issue_mode          = mode;
  assign slot0_is_delay_slot = (state == DS_PEND) && fifo_valid_0;

  // A branch issued without its delay slot parks in DS_PEND until the slot issues alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else if (ds_flush) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else if (ds_allowin) begin
      case (state)
        IDLE:    if (mode == MODE_SINGLE && branch0) state <= DS_PEND;
        DS_PEND: if (mode != MODE_NONE) state <= IDLE;
      endcase
      if (state == IDLE && fifo_valid_0 && branch0 && mode == MODE_NONE) begin
        if (wait_cnt != WAIT_LIM)
          wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  logic [CNT_W-1:0] dual_q, single_q, bubble_q;

  // Flush cycles produce MODE_NONE but are excluded from the bubble count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dual_q   <= '0;
      single_q <= '0;
      bubble_q <= '0;
    end else begin
      if (mode == MODE_DUAL)
        dual_q <= dual_q + 1'b1;
      if (mode == MODE_SINGLE)
        single_q <= single_q + 1'b1;
      if (mode == MODE_NONE && fifo_valid_0 && ds_allowin && !ds_flush)
        bubble_q <= bubble_q + 1'b1;
    end
  end

  assign perf_dual_cnt   = dual_q;
  assign perf_single_cnt = single_q;
  assign perf_bubble_cnt = bubble_q;
`else
  assign perf_dual_cnt   = '0;
  assign perf_single_cnt = '0;
  assign perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Testbench for issue_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_issue_ctrl;

  localparam int WAIT_MAX = 2;
  localparam int CNT_W    = 32;
`ifdef ISSUE_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam int ADDU = 33;
  localparam int ADD  = 32;
  localparam int JR   = 8;
  localparam int JALR = 9;
  localparam int MULT = 24;
  localparam int MFHI = 16;
  localparam int SYSC = 12;

  logic             clk = 1'b0;
  logic             reset;
  logic             fifo_valid_0, fifo_valid_1;
  logic [31:0]      fifo_inst_0, fifo_inst_1;
  logic             fifo_ex_0, fifo_ex_1;
  logic             ds_allowin, ds_flush;
  logic [1:0]       issue_mode;
  logic             slot0_is_delay_slot;
  logic [CNT_W-1:0] perf_dual_cnt, perf_single_cnt, perf_bubble_cnt;

  int errors = 0;
  int checks = 0;

  bit          m_pend;
  int          m_wait;
  int unsigned m_dual, m_single, m_bubble;

  always #5 clk = ~clk;

  issue_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .reset               (reset),
    .fifo_valid_0        (fifo_valid_0),
    .fifo_valid_1        (fifo_valid_1),
    .fifo_inst_0         (fifo_inst_0),
    .fifo_inst_1         (fifo_inst_1),
    .fifo_ex_0           (fifo_ex_0),
    .fifo_ex_1           (fifo_ex_1),
    .ds_allowin          (ds_allowin),
    .ds_flush            (ds_flush),
    .issue_mode          (issue_mode),
    .slot0_is_delay_slot (slot0_is_delay_slot),
    .perf_dual_cnt       (perf_dual_cnt),
    .perf_single_cnt     (perf_single_cnt),
    .perf_bubble_cnt     (perf_bubble_cnt)
  );

  function automatic logic [31:0] r_type(input int rs, input int rt, input int rd, input int func);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, 6'(func)};
  endfunction

  function automatic logic [31:0] i_type(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // Instruction classification from the ISA rules, on integer fields.
  function automatic int tb_dest(input logic [31:0] w);
    int op, rt, rd, d;
    op = int'(w[31:26]); rt = int'(w[20:16]); rd = int'(w[15:11]);
    d = 0;
    if (op == 0) d = rd;
    else if (op / 8 == 1 || op / 8 == 4) d = rt;
    else if (op == 3 || (op == 1 && (rt == 16 || rt == 17))) d = 31;
    return d;
  endfunction

  function automatic bit tb_branch(input logic [31:0] w);
    int op, rt, fn;
    op = int'(w[31:26]); rt = int'(w[20:16]); fn = int'(w[5:0]);
    return (op >= 2 && op <= 7) || (op == 1 && rt inside {0, 1, 16, 17})
        || (op == 0 && fn inside {8, 9});
  endfunction

  function automatic bit tb_mem(input logic [31:0] w);
    return int'(w[31:26]) / 16 == 2;
  endfunction

  function automatic bit tb_muldiv(input logic [31:0] w);
    int op, fn;
    op = int'(w[31:26]); fn = int'(w[5:0]);
    return op == 0 && (fn / 8 == 3 || fn / 4 == 4);
  endfunction

  function automatic bit tb_priv(input logic [31:0] w);
    int op, fn;
    op = int'(w[31:26]); fn = int'(w[5:0]);
    return op == 16 || (op == 0 && (fn == 12 || fn == 13));
  endfunction

  function automatic bit tb_pair_ok();
    int d0;
    d0 = tb_dest(fifo_inst_0);
    if (!fifo_valid_0 || !fifo_valid_1) return 1'b0;
    if (fifo_ex_0 || fifo_ex_1) return 1'b0;
    if (tb_priv(fifo_inst_0) || tb_priv(fifo_inst_1)) return 1'b0;
    if (tb_branch(fifo_inst_1)) return 1'b0;
    if (d0 != 0 && (d0 == int'(fifo_inst_1[25:21]) || d0 == int'(fifo_inst_1[20:16]))) return 1'b0;
    if (tb_mem(fifo_inst_0) && tb_mem(fifo_inst_1)) return 1'b0;
    if (tb_muldiv(fifo_inst_0) && tb_muldiv(fifo_inst_1)) return 1'b0;
    return 1'b1;
  endfunction

  // Expected issue count this cycle: 0 none, 1 single, 2 dual.
  function automatic int exp_mode();
    if (ds_flush || !ds_allowin || !fifo_valid_0) return 0;
    if (m_pend) return 1;
    if (tb_pair_ok()) return 2;
    if (!tb_branch(fifo_inst_0)) return 1;
    if (fifo_valid_1 || m_wait >= WAIT_MAX) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] exp_cnt(input int unsigned v);
    return CNT_EN ? 32'(v) : 32'd0;
  endfunction

  task automatic model_reset();
    m_pend = 1'b0; m_wait = 0;
    m_dual = 0; m_single = 0; m_bubble = 0;
  endtask

  task automatic model_step();
    int m;
    m = exp_mode();
    if (m == 2) m_dual++;
    else if (m == 1) m_single++;
    else if (fifo_valid_0 && ds_allowin && !ds_flush) m_bubble++;
    if (ds_flush) begin
      m_pend = 1'b0; m_wait = 0;
    end else if (ds_allowin) begin
      if (m != 0) begin
        m_wait = 0;
        m_pend = !m_pend && m == 1 && tb_branch(fifo_inst_0);
      end else if (fifo_valid_0 && !m_pend && tb_branch(fifo_inst_0)) begin
        m_wait = (m_wait < WAIT_MAX) ? m_wait + 1 : m_wait;
      end else begin
        m_wait = 0;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic put(input bit v0, input logic [31:0] w0, input bit v1, input logic [31:0] w1);
    fifo_valid_0 = v0; fifo_inst_0 = w0;
    fifo_valid_1 = v1; fifo_inst_1 = w1;
  endtask

  function automatic logic [31:0] rand_inst();
    int rs, rt, rd;
    logic [31:0] w;
    rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 7);
    case ($urandom_range(0, 15))
      0:       w = r_type(rs, rt, rd, ADDU);
      1:       w = i_type(35, rs, rt, 0);
      2:       w = i_type(43, rs, rt, 4);
      3:       w = r_type(rs, rt, 0, MULT);
      4:       w = r_type(0, 0, rd, MFHI);
      5:       w = i_type(4, rs, rt, 4);
      6:       w = i_type(2, 0, 0, 16);
      7:       w = i_type(3, 0, 0, 16);
      8:       w = r_type(rs, 0, 0, JR);
      9:       w = r_type(rs, 0, rd, JALR);
      10:      w = i_type(1, rs, 17, 4);
      11:      w = r_type(0, 0, 0, SYSC);
      12:      w = i_type(16, 4, rt, rd * 2048);
      13:      w = i_type(8, rs, rt, 1);
      14:      w = i_type(1, rs, 0, 4);
      default: w = i_type(15, 0, rt, 255);
    endcase
    return w;
  endfunction

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    checks++; if (issue_mode !== 2'b00) begin errors++; $display("[TB] FAIL reset_mode: got %0d expected 0", issue_mode); end
    checks++; if (slot0_is_delay_slot !== 1'b0) begin errors++; $display("[TB] FAIL reset_ds: got %0d expected 0", slot0_is_delay_slot); end
    checks++; if (perf_dual_cnt !== '0 || perf_single_cnt !== '0 || perf_bubble_cnt !== '0) begin
      errors++; $display("[TB] FAIL reset_cnt: got %0d/%0d/%0d expected 0/0/0", perf_dual_cnt, perf_single_cnt, perf_bubble_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_raw_hazard();
    put(1, r_type(1, 2, 3, ADDU), 1, r_type(3, 5, 4, ADDU));
    #1;
    checks++; if (issue_mode !== 2'b01) begin errors++; $display("[TB] FAIL raw_single: got %0d expected 1", issue_mode); end
    cycle();
    put(1, r_type(1, 2, 3, ADDU), 1, r_type(6, 5, 4, ADDU));
    #1;
    checks++; if (issue_mode !== 2'b10) begin errors++; $display("[TB] FAIL raw_dual: got %0d expected 2", issue_mode); end
    checks++; if (perf_dual_cnt !== exp_cnt(0)) begin errors++; $display("[TB] FAIL dual_cnt_before: got %0d expected %0d", perf_dual_cnt, exp_cnt(0)); end
    cycle();
    #1;
    checks++; if (perf_dual_cnt !== exp_cnt(1)) begin errors++; $display("[TB] FAIL dual_cnt_after: got %0d expected %0d", perf_dual_cnt, exp_cnt(1)); end
  endtask

  task automatic test_mem_pair();
    put(1, i_type(35, 1, 2, 0), 1, i_type(43, 4, 3, 8));
    #1;
    checks++; if (issue_mode !== 2'b01) begin errors++; $display("[TB] FAIL mem_mem: got %0d expected 1", issue_mode); end
    cycle();
    put(1, i_type(35, 1, 2, 0), 1, r_type(6, 7, 5, ADD));
    #1;
    checks++; if (issue_mode !== 2'b10) begin errors++; $display("[TB] FAIL mem_alu: got %0d expected 2", issue_mode); end
    cycle();
  endtask

  task automatic test_branch_wait();
    put(1, i_type(4, 1, 2, 4), 0, 32'd0);
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (issue_mode !== 2'b00) begin errors++; $display("[TB] FAIL br_wait%0d: got %0d expected 0", k, issue_mode); end
      cycle();
    end
    #1;
    checks++; if (perf_bubble_cnt !== exp_cnt(2)) begin errors++; $display("[TB] FAIL bubble_cnt: got %0d expected %0d", perf_bubble_cnt, exp_cnt(2)); end
    checks++; if (issue_mode !== 2'b01) begin errors++; $display("[TB] FAIL br_alone: got %0d expected 1", issue_mode); end
    cycle();
    put(1, r_type(1, 2, 3, ADDU), 1, r_type(6, 5, 4, ADDU));
    #1;
    checks++; if (slot0_is_delay_slot !== 1'b1) begin errors++; $display("[TB] FAIL ds_flag: got %0d expected 1", slot0_is_delay_slot); end
    checks++; if (issue_mode !== 2'b01) begin errors++; $display("[TB] FAIL ds_single: got %0d expected 1", issue_mode); end
    cycle();
    #1;
    checks++; if (slot0_is_delay_slot !== 1'b0 || issue_mode !== 2'b10) begin
      errors++; $display("[TB] FAIL ds_return: got ds=%0d mode=%0d expected ds=0 mode=2", slot0_is_delay_slot, issue_mode);
    end
    cycle();
  endtask

  task automatic test_flush_ds();
    put(1, i_type(3, 0, 0, 16), 1, r_type(31, 0, 5, ADDU));
    #1;
    checks++; if (issue_mode !== 2'b01) begin errors++; $display("[TB] FAIL jal_single: got %0d expected 1", issue_mode); end
    cycle();
    put(1, r_type(31, 0, 5, ADDU), 1, r_type(6, 7, 4, ADDU));
    ds_flush = 1'b1;
    #1;
    checks++; if (issue_mode !== 2'b00) begin errors++; $display("[TB] FAIL flush_mode: got %0d expected 0", issue_mode); end
    cycle();
    ds_flush = 1'b0;
    #1;
    checks++; if (slot0_is_delay_slot !== 1'b0) begin errors++; $display("[TB] FAIL flush_ds: got %0d expected 0", slot0_is_delay_slot); end
    checks++; if (issue_mode !== 2'b10) begin errors++; $display("[TB] FAIL flush_idle: got %0d expected 2", issue_mode); end
    cycle();
  endtask

  task automatic test_slot1_branch_ex();
    put(1, r_type(1, 2, 3, ADDU), 1, i_type(4, 7, 8, 4));
    #1;
    checks++; if (issue_mode !== 2'b01) begin errors++; $display("[TB] FAIL slot1_branch: got %0d expected 1", issue_mode); end
    cycle();
    put(1, r_type(1, 2, 3, ADDU), 1, r_type(6, 5, 4, ADDU));
    fifo_ex_0 = 1'b1;
    #1;
    checks++; if (issue_mode !== 2'b01) begin errors++; $display("[TB] FAIL ex0_single: got %0d expected 1", issue_mode); end
    cycle();
    fifo_ex_0 = 1'b0;
  endtask

  task automatic test_stall();
    put(1, i_type(4, 1, 2, 4), 0, 32'd0);
    #1;
    checks++; if (issue_mode !== 2'b00) begin errors++; $display("[TB] FAIL stall_w0: got %0d expected 0", issue_mode); end
    cycle();
    ds_allowin = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (issue_mode !== 2'b00) begin errors++; $display("[TB] FAIL stall_hold%0d: got %0d expected 0", k, issue_mode); end
      cycle();
    end
    ds_allowin = 1'b1;
    #1;
    checks++; if (issue_mode !== 2'b00) begin errors++; $display("[TB] FAIL stall_w1: got %0d expected 0", issue_mode); end
    cycle();
    #1;
    checks++; if (issue_mode !== 2'b01) begin errors++; $display("[TB] FAIL stall_issue: got %0d expected 1", issue_mode); end
    cycle();
    put(1, r_type(1, 2, 3, ADDU), 0, 32'd0);
    #1;
    checks++; if (slot0_is_delay_slot !== 1'b1) begin errors++; $display("[TB] FAIL stall_ds: got %0d expected 1", slot0_is_delay_slot); end
    cycle();
  endtask

  task automatic test_reset_mid();
    put(1, i_type(3, 0, 0, 16), 1, r_type(31, 0, 5, ADDU));
    #1;
    cycle();
    put(1, r_type(1, 2, 3, ADDU), 0, 32'd0);
    #1;
    checks++; if (slot0_is_delay_slot !== 1'b1) begin errors++; $display("[TB] FAIL mid_pend: got %0d expected 1", slot0_is_delay_slot); end
    #1 reset = 1'b1;
    model_reset();
    #1;
    checks++; if (slot0_is_delay_slot !== 1'b0) begin errors++; $display("[TB] FAIL mid_ds: got %0d expected 0", slot0_is_delay_slot); end
    checks++; if (perf_dual_cnt !== '0 || perf_single_cnt !== '0 || perf_bubble_cnt !== '0) begin
      errors++; $display("[TB] FAIL mid_cnt: got %0d/%0d/%0d expected 0/0/0", perf_dual_cnt, perf_single_cnt, perf_bubble_cnt);
    end
    put(0, 32'd0, 0, 32'd0);
    #1;
    checks++; if (issue_mode !== 2'b00) begin errors++; $display("[TB] FAIL mid_mode: got %0d expected 0", issue_mode); end
    reset = 1'b0;
    cycle();
    put(1, i_type(4, 1, 2, 4), 0, 32'd0);
    #1;
    cycle();
    #1 reset = 1'b1;
    model_reset();
    #1 reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (issue_mode !== 2'b00) begin errors++; $display("[TB] FAIL wait_clr%0d: got %0d expected 0", k, issue_mode); end
      cycle();
    end
    #1;
    checks++; if (issue_mode !== 2'b01) begin errors++; $display("[TB] FAIL wait_clr_issue: got %0d expected 1", issue_mode); end
    cycle();
  endtask

  task automatic test_random();
    int em;
    bit esd;
    for (int n = 0; n < 400; n++) begin
      put($urandom_range(0, 7) != 0, rand_inst(), $urandom_range(0, 3) != 0, rand_inst());
      fifo_ex_0  = ($urandom_range(0, 15) == 0);
      fifo_ex_1  = ($urandom_range(0, 15) == 0);
      ds_allowin = ($urandom_range(0, 7) != 0);
      ds_flush   = ($urandom_range(0, 15) == 0);
      #1;
      em  = exp_mode();
      esd = m_pend && fifo_valid_0;
      checks++; if (issue_mode !== 2'(em)) begin errors++; $display("[TB] FAIL rnd_mode[%0d]: got %0d expected %0d", n, issue_mode, em); end
      checks++; if (slot0_is_delay_slot !== esd) begin errors++; $display("[TB] FAIL rnd_ds[%0d]: got %0d expected %0d", n, slot0_is_delay_slot, esd); end
      checks++; if (perf_dual_cnt !== exp_cnt(m_dual)) begin errors++; $display("[TB] FAIL rnd_dual[%0d]: got %0d expected %0d", n, perf_dual_cnt, exp_cnt(m_dual)); end
      checks++; if (perf_single_cnt !== exp_cnt(m_single)) begin errors++; $display("[TB] FAIL rnd_single[%0d]: got %0d expected %0d", n, perf_single_cnt, exp_cnt(m_single)); end
      checks++; if (perf_bubble_cnt !== exp_cnt(m_bubble)) begin errors++; $display("[TB] FAIL rnd_bubble[%0d]: got %0d expected %0d", n, perf_bubble_cnt, exp_cnt(m_bubble)); end
      cycle();
    end
  endtask

  initial begin
    reset = 1'b0;
    put(0, 32'd0, 0, 32'd0);
    fifo_ex_0 = 1'b0; fifo_ex_1 = 1'b0;
    ds_allowin = 1'b1; ds_flush = 1'b0;
    model_reset();
    test_reset();
    test_raw_hazard();
    test_mem_pair();
    test_branch_wait();
    test_flush_ds();
    test_slot1_branch_ex();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
